vta_axi_dpi_bridge: RTL
=======================

VTA_AXI_DPI_BRIDGE -- requirements
Module: vta_axi_dpi_bridge

Interface
REQ-001 SHALL have parameters: LEN_BITS, 8, AXI/DPI burst-length width; ADDR_BITS, 64, address width; DATA_BITS, 64, data width (multiple of 64); STRB_BITS, DATA_BITS/8, write-strobe width.
REQ-002 SHALL have ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ar_valid, ar_ready  in, out  1  AXI read-address handshake
- ar_addr, ar_len, ar_id  in  ADDR_BITS, LEN_BITS, 8  read address, beats-1, ID
- r_valid, r_ready  out, in  1  AXI read-data handshake
- r_data, r_id, r_last  out  DATA_BITS, 8, 1  read beat payload
- aw_valid, aw_ready  in, out  1  AXI write-address handshake
- aw_addr, aw_len  in  ADDR_BITS, LEN_BITS  write address, beats-1
- w_valid, w_ready  in, out  1  AXI write-data handshake
- w_data, w_strb, w_last  in  DATA_BITS, STRB_BITS, 1  write beat
- b_valid, b_ready  out, in  1  write-response handshake
- dpi_req_ar_valid, dpi_req_ar_len, dpi_req_ar_id, dpi_req_ar_addr  out  1, LEN_BITS, 8, ADDR_BITS  read request to memory model
- dpi_req_aw_valid, dpi_req_aw_len, dpi_req_aw_addr  out  1, LEN_BITS, ADDR_BITS  write request to memory model
- dpi_wr_valid, dpi_wr_bits_data, dpi_wr_bits_strb  out  1, DATA_BITS, STRB_BITS  write beat to memory model
- dpi_rd_valid, dpi_rd_bits_id, dpi_rd_bits_data  in  1, 8, DATA_BITS  read beat from memory model
- dpi_rd_ready  out  1  read-beat accept to memory model
- err  out  1  sticky protocol-error flag

Function
REQ-003 Read FSM SHALL have states RD_IDLE, RD_DATA; ar_ready=1 only in RD_IDLE.
REQ-004 On ar_valid&ar_ready, SHALL register addr/len/id, drive dpi_req_ar_* with them for exactly the next cycle (single-cycle pulse), load rd_cnt=ar_len, enter RD_DATA.
REQ-005 In RD_DATA: r_valid=dpi_rd_valid, r_data=dpi_rd_bits_data, r_id=dpi_rd_bits_id, dpi_rd_ready=r_ready, all combinational; r_last=(rd_cnt==0); outside RD_DATA r_valid=0, dpi_rd_ready=0.
REQ-006 Each r_valid&r_ready beat SHALL decrement rd_cnt; beat with rd_cnt==0 SHALL return to RD_IDLE next cycle.
REQ-007 Write FSM SHALL have states WR_IDLE, WR_DATA, WR_RESP; aw_ready=1 only in WR_IDLE.
REQ-008 On aw_valid&aw_ready, SHALL register addr/len, pulse dpi_req_aw_* for exactly the next cycle, load wr_cnt=aw_len, enter WR_DATA.
REQ-009 In WR_DATA: w_ready=1 except in the cycle dpi_req_aw_valid is high; dpi_wr_valid=w_valid&w_ready, dpi_wr_bits_data=w_data, dpi_wr_bits_strb=w_strb.
REQ-010 Each accepted W beat SHALL decrement wr_cnt; beat with wr_cnt==0 SHALL enter WR_RESP; w_last SHALL NOT affect beat counting.
REQ-011 In WR_RESP b_valid=1, held until b_ready; then WR_IDLE next cycle.
REQ-012 Read and write FSMs SHALL run independently; simultaneous AR and AW handshakes in one cycle SHALL both be accepted.
REQ-013 ar_len/aw_len=0 SHALL yield single-beat bursts; len=2^LEN_BITS-1 SHALL produce 2^LEN_BITS beats without counter wrap.
REQ-014 dpi_req_*_valid, dpi_wr_valid SHALL never assert while reset is high.

Reset
REQ-015 On reset (synchronous), both FSMs SHALL enter *_IDLE, counters and captured fields 0, err 0; any in-flight burst SHALL be abandoned with no response.
REQ-016 In the cycle after reset deasserts: ar_ready=1, aw_ready=1, all other outputs 0.

Configuration
REQ-017 With VTA_AXI_DPI_PROTOCOL_CHECK_EN defined, err SHALL set (sticky until reset) when an accepted W beat has w_last!=(wr_cnt==0) or an accepted R beat has dpi_rd_bits_id!=captured ar_id.
REQ-018 Without VTA_AXI_DPI_PROTOCOL_CHECK_EN, err SHALL be constant 0 and no check logic SHALL be present; all other behaviour identical.

Verification
REQ-019 AR addr=0x1000 len=3 id=0x5 -> one-cycle dpi_req_ar pulse with same fields; 4 R beats id 0x5, r_last only on 4th; ar_ready back 1 after.
REQ-020 AW addr=0x2000 len=1, W beats 0xA/0xB strb 0xFF -> dpi_req_aw pulse, two dpi_wr_valid beats, then b_valid held until b_ready, then aw_ready=1.
REQ-021 r_ready low 5 cycles mid-burst with dpi_rd_valid high -> dpi_rd_ready low, no beat lost/duplicated, rd_cnt unchanged.
REQ-022 AR and AW same cycle, len=0 each -> both pulses next cycle; read and write complete independently.
REQ-023 Reset asserted during WR_DATA after 1 of 4 beats -> next cycle all FSMs idle, b_valid never asserted, err=0.
REQ-024 (macro defined) w_last=1 on beat 1 of len=2 burst -> err=1 next cycle, stays 1 until reset; (undefined) err stays 0.

Source files
------------

// File: rtl/vta_axi_dpi_bridge.sv
// AXI-to-DPI memory-model bridge: independent read/write FSMs; dpi_req_* pulse one cycle after the address handshake.
// Backpressure: R/W beats pass through combinationally; r_ready and w_ready/b_ready stall the bursts.
// Optional protocol checker (sticky err) under `VTA_AXI_DPI_PROTOCOL_CHECK_EN.
module vta_axi_dpi_bridge #(
    parameter int LEN_BITS  = 8,
    parameter int ADDR_BITS = 64,
    parameter int DATA_BITS = 64,
    parameter int STRB_BITS = DATA_BITS / 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [ADDR_BITS-1:0] ar_addr_i,
    input  logic [LEN_BITS-1:0]  ar_len_i,
    input  logic [7:0]           ar_id_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [DATA_BITS-1:0] r_data_o,
    output logic [7:0]           r_id_o,
    output logic                 r_last_o,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [ADDR_BITS-1:0] aw_addr_i,
    input  logic [LEN_BITS-1:0]  aw_len_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic [DATA_BITS-1:0] w_data_i,
    input  logic [STRB_BITS-1:0] w_strb_i,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic                 dpi_req_ar_valid_o,
    output logic [LEN_BITS-1:0]  dpi_req_ar_len_o,
    output logic [7:0]           dpi_req_ar_id_o,
    output logic [ADDR_BITS-1:0] dpi_req_ar_addr_o,
    output logic                 dpi_req_aw_valid_o,
    output logic [LEN_BITS-1:0]  dpi_req_aw_len_o,
    output logic [ADDR_BITS-1:0] dpi_req_aw_addr_o,
    output logic                 dpi_wr_valid_o,
    output logic [DATA_BITS-1:0] dpi_wr_bits_data_o,
    output logic [STRB_BITS-1:0] dpi_wr_bits_strb_o,
    input  logic                 dpi_rd_valid_i,
    input  logic [7:0]           dpi_rd_bits_id_i,
    input  logic [DATA_BITS-1:0] dpi_rd_bits_data_i,
    output logic                 dpi_rd_ready_o,
    output logic                 err_o
);

    typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_e;

    rd_state_e            rd_state_q;
    logic [ADDR_BITS-1:0] ar_addr_q;
    logic [LEN_BITS-1:0]  ar_len_q;
    logic [LEN_BITS-1:0]  rd_cnt_q;
    logic [7:0]           ar_id_q;
    logic                 ar_pulse_q;

    wr_state_e            wr_state_q;
    logic [ADDR_BITS-1:0] aw_addr_q;
    logic [LEN_BITS-1:0]  aw_len_q;
    logic [LEN_BITS-1:0]  wr_cnt_q;
    logic                 aw_pulse_q;

    logic rd_active, wr_active, r_fire, w_fire;

    assign rd_active = (rd_state_q == RD_DATA);
    assign wr_active = (wr_state_q == WR_DATA);

    // Read channel: beats flow straight from the memory model while a burst is open.
    assign ar_ready_o     = (rd_state_q == RD_IDLE);
    assign r_valid_o      = rd_active & dpi_rd_valid_i;
    assign r_data_o       = rd_active ? dpi_rd_bits_data_i : '0;
    assign r_id_o         = rd_active ? dpi_rd_bits_id_i : '0;
    assign r_last_o       = rd_active & (rd_cnt_q == '0);
    assign dpi_rd_ready_o = rd_active & r_ready_i;
    assign r_fire         = r_valid_o & r_ready_i;

    assign dpi_req_ar_valid_o = ar_pulse_q & ~reset;
    assign dpi_req_ar_len_o   = ar_len_q;
    assign dpi_req_ar_id_o    = ar_id_q;
    assign dpi_req_ar_addr_o  = ar_addr_q;

    // Write data is held off during the request pulse so the model sees the request first.
    assign aw_ready_o         = (wr_state_q == WR_IDLE);
    assign w_ready_o          = wr_active & ~aw_pulse_q;
    assign w_fire             = w_valid_i & w_ready_o;
    assign b_valid_o          = (wr_state_q == WR_RESP);
    assign dpi_wr_valid_o     = w_fire & ~reset;
    assign dpi_wr_bits_data_o = wr_active ? w_data_i : '0;
    assign dpi_wr_bits_strb_o = wr_active ? w_strb_i : '0;

    assign dpi_req_aw_valid_o = aw_pulse_q & ~reset;
    assign dpi_req_aw_len_o   = aw_len_q;
    assign dpi_req_aw_addr_o  = aw_addr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state_q <= RD_IDLE;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_id_q    <= '0;
            rd_cnt_q   <= '0;
            ar_pulse_q <= 1'b0;
        end else begin
            ar_pulse_q <= 1'b0;
            case (rd_state_q)
                RD_IDLE: if (ar_valid_i) begin
                    ar_addr_q  <= ar_addr_i;
                    ar_len_q   <= ar_len_i;
                    ar_id_q    <= ar_id_i;
                    rd_cnt_q   <= ar_len_i;
                    ar_pulse_q <= 1'b1;
                    rd_state_q <= RD_DATA;
                end
                RD_DATA: if (r_fire) begin
                    if (rd_cnt_q == '0) rd_state_q <= RD_IDLE;
                    else                rd_cnt_q   <= rd_cnt_q - 1'b1;
                end
            endcase
        end
    end

    // Counters stop at zero on the final beat, so a full-length burst never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_q <= WR_IDLE;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            wr_cnt_q   <= '0;
            aw_pulse_q <= 1'b0;
        end else begin
            aw_pulse_q <= 1'b0;
            case (wr_state_q)
                WR_IDLE: if (aw_valid_i) begin
                    aw_addr_q  <= aw_addr_i;
                    aw_len_q   <= aw_len_i;
                    wr_cnt_q   <= aw_len_i;
                    aw_pulse_q <= 1'b1;
                    wr_state_q <= WR_DATA;
                end
                WR_DATA: if (w_fire) begin
                    if (wr_cnt_q == '0) wr_state_q <= WR_RESP;
                    else                wr_cnt_q   <= wr_cnt_q - 1'b1;
                end
                WR_RESP: if (b_ready_i) wr_state_q <= WR_IDLE;
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

`ifdef VTA_AXI_DPI_PROTOCOL_CHECK_EN
    logic err_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if ((w_fire && (w_last_i != (wr_cnt_q == '0))) ||
                     (r_fire && (dpi_rd_bits_id_i != ar_id_q))) begin
            err_q <= 1'b1;
        end
    end
    assign err_o = err_q;
`else
    logic unused_w_last;
    assign unused_w_last = w_last_i;
    assign err_o         = 1'b0;
`endif

endmodule
